shift_reg_multi: RTL and testbench
==================================

Name: shift_reg_multi

Overview:
Parametrised multi-bit shift register and successor to the 1-bit serial shifter. It holds DEPTH stages of WIDTH bits each and supports several operations:
- shift in either direction, optionally rotating;
- synchronous parallel load;
- full parallel readout;
- a fill counter that tracks how many valid words are in the pipe.

It serves as the general delay line and serialiser building block for datapath and I/O staging.

Parameters:
WIDTH, 8, bits per stage (>=1)
DEPTH, 4, number of stages (>=1)
CNT_W, $clog2(DEPTH+1), width of the fill counter (derived; do not override)

Ports:
clk  input  1  clock; all state updates on posedge
rst_b  input  1  asynchronous active-low reset
enable  input  1  perform one shift this cycle
dir  input  1  0 = shift toward higher stage index; 1 = toward lower index
rotate  input  1  1 = re-inject the word shifted out instead of sin
ld_par  input  1  synchronous parallel load from pin
clr  input  1  synchronous clear of all stages and the counter
sin  input  WIDTH  serial word input
pin  input  WIDTH*DEPTH  parallel load data; stage i = pin[i*WIDTH +: WIDTH]
sout  output  WIDTH  serial output word
pout  output  WIDTH*DEPTH  parallel view; stage i at pout[i*WIDTH +: WIDTH]
fill_cnt  output  CNT_W  valid words held, saturating at DEPTH
full  output  1  fill_cnt == DEPTH

Behaviour:
- Storage is DEPTH registers stage[0..DEPTH-1], each WIDTH bits.
- Reset (rst_b low, asynchronous, immediate):
  - all stages = 0, fill_cnt = 0;
  - therefore pout = 0, sout = 0, full = 0.
  - A reset mid-shift discards all data.
  - The first posedge after rst_b rises acts normally.
- Per-cycle priority is clr > ld_par > enable > hold.
- clr: all stages <= 0 and fill_cnt <= 0. Other controls are ignored.
- ld_par: stage[i] <= pin slice i and fill_cnt <= DEPTH. enable, dir and rotate are ignored.
- enable with dir=0:
  - stage[i] <= stage[i-1] for i >= 1;
  - stage[0] <= rotate ? stage[DEPTH-1] : sin.
- enable with dir=1:
  - stage[i] <= stage[i+1] for i <= DEPTH-2;
  - stage[DEPTH-1] <= rotate ? stage[0] : sin.
- fill_cnt on shift:
  - rotate=1: unchanged;
  - rotate=0: fill_cnt + 1, saturating at DEPTH (no wrap).
- Hold (enable=0 and no clr/ld_par): all state unchanged; sin is ignored.
- sout is combinational from registered state only (no input-to-output path):
  - sout = stage[DEPTH-1] when dir=0;
  - sout = stage[0] when dir=1.
- Latency: with dir=0 and rotate=0, a word sampled on sin at enabled edge k appears on sout after the DEPTH-th enabled edge counting from k. Disabled cycles stall the pipe without loss.
- DEPTH=1 corner: rotate leaves the stage unchanged; a non-rotate shift replaces the single stage with sin.
- pout and full are purely registered-state derived, with no glitch path from inputs.
- Changing dir between shifts is legal and takes effect the same cycle. fill_cnt is not recomputed on a dir change.

Test Plan:
All scenarios use WIDTH=8, DEPTH=4.
1. Reset:
   - Stimulus: hold rst_b=0 with random inputs and clk running; then assert rst_b=0 again while shifting.
   - Required: pout=0x00000000, sout=0x00, fill_cnt=0 and full=0 immediately on each assertion, without waiting for a clock edge.
2. Serial fill:
   - Stimulus: dir=0, rotate=0, enable=1; sin=0x11, 0x22, 0x33, 0x44 on 4 edges.
   - Required: fill_cnt = 1, 2, 3, 4; full=1 after the 4th edge; pout=0x11223344 (stage3=0x11); sout=0x11.
   - Continued: a 5th shift with sin=0x55 gives sout=0x22 and fill_cnt stays 4.
3. Parallel load and rotate:
   - Stimulus: ld_par with pin=0x44332211 gives fill_cnt=4, sout=0x44. Then enable=1, rotate=1, dir=0 for one edge.
   - Required: pout=0x33221144, sout=0x33, fill_cnt=4. Three further rotates return pout to 0x44332211.
4. Reverse shift:
   - Stimulus: load 0x44332211, then dir=1, rotate=0, sin=0xAA, one enabled edge.
   - Required: pout=0xAA443322; sout=0x22 (stage0).
5. Hold and priority:
   - Stimulus: enable=0 for 5 cycles while sin toggles.
   - Required: pout unchanged throughout.
   - Stimulus: clr=1, ld_par=1 and enable=1 on the same edge.
   - Required: pout=0, fill_cnt=0.
   - Stimulus: ld_par=1 and enable=1 on the same edge.
   - Required: pout=pin exactly (no shift applied).
6. Stall latency:
   - Stimulus: dir=0 after clr; a marker 0x5A enters on the first enabled edge; enable=0 is interleaved on alternate cycles.
   - Required: 0x5A appears on sout exactly after the 4th enabled edge.

Source files
------------

// File: rtl/shift_reg_multi_if.sv
// Control and data bundle for shift_reg_multi.
// The master drives the controls and the slave (the shifter) drives the observed state.
interface shift_reg_multi_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic                     enable;
    logic                     dir;
    logic                     rotate;
    logic                     ld_par;
    logic                     clr;
    logic [WIDTH-1:0]         sin;
    logic [WIDTH*DEPTH-1:0]   pin;
    logic [WIDTH-1:0]         sout;
    logic [WIDTH*DEPTH-1:0]   pout;
    logic [CNT_W-1:0]         fill_cnt;
    logic                     full;

    modport master (
        output enable, dir, rotate, ld_par, clr, sin, pin,
        input  sout, pout, fill_cnt, full
    );

    modport slave (
        input  enable, dir, rotate, ld_par, clr, sin, pin,
        output sout, pout, fill_cnt, full
    );
endinterface

// File: rtl/shift_reg_multi.sv
// DEPTH x WIDTH bidirectional shift register with optional rotate, parallel load/readout
// and a saturating fill counter.
module shift_reg_multi #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    shift_reg_multi_if.slave     bus
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];
    logic [WIDTH-1:0] up_w    [DEPTH];
    logic [WIDTH-1:0] down_w  [DEPTH];
    logic [CNT_W-1:0] fill_q;
    logic [CNT_W-1:0] fill_d;

    // Candidate next values for both shift directions; the end stage takes sin or the
    // word falling off the opposite end. With DEPTH=1 a rotate reloads the stage itself.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_shift
        if (gi == 0) begin : g_up_end
            assign up_w[gi] = bus.rotate ? stage_q[DEPTH-1] : bus.sin;
        end else begin : g_up_mid
            assign up_w[gi] = stage_q[gi-1];
        end
        if (gi == DEPTH - 1) begin : g_dn_end
            assign down_w[gi] = bus.rotate ? stage_q[0] : bus.sin;
        end else begin : g_dn_mid
            assign down_w[gi] = stage_q[gi+1];
        end
        assign bus.pout[gi*WIDTH +: WIDTH] = stage_q[gi];
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i];
        end
        fill_d = fill_q;
        if (bus.clr) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = '0;
            end
            fill_d = '0;
        end else if (bus.ld_par) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = bus.pin[i*WIDTH +: WIDTH];
            end
            fill_d = FULL_CNT;
        end else if (bus.enable) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_d[i] = bus.dir ? down_w[i] : up_w[i];
            end
            // Rotation recirculates existing words, so only fresh sin words count.
            if (!bus.rotate && fill_q != FULL_CNT) begin
                fill_d = fill_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            fill_q <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= stage_d[i];
            end
            fill_q <= fill_d;
        end
    end

    assign bus.sout     = bus.dir ? stage_q[0] : stage_q[DEPTH-1];
    assign bus.fill_cnt = fill_q;
    assign bus.full     = (fill_q == FULL_CNT);
endmodule

// File: tb/tb_shift_reg_multi.sv
// Directed bench for shift_reg_multi at WIDTH=8, DEPTH=4 with hand-computed expectations.
module tb_shift_reg_multi;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic clk;
    logic rst_b;
    int   checks_total;
    int   checks_pass;

    shift_reg_multi_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();

    shift_reg_multi #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk   (clk),
        .rst_b (rst_b),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks_total++;
        if (obs === exp) begin
            checks_pass++;
            $display("ok   %-14s got=0x%0h", tag, obs);
        end else begin
            $display("FAIL %-14s got=0x%0h want=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic en, input logic d, input logic rot, input logic ld,
                         input logic c, input logic [7:0] s, input logic [31:0] p);
        bus.enable = en;
        bus.dir    = d;
        bus.rotate = rot;
        bus.ld_par = ld;
        bus.clr    = c;
        bus.sin    = s;
        bus.pin    = p;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all(input string tag, input logic [31:0] pout_e, input logic [7:0] sout_e,
                           input logic [2:0] fill_e, input logic full_e);
        chk({tag, ".pout"}, 64'(bus.pout), 64'(pout_e));
        chk({tag, ".sout"}, 64'(bus.sout), 64'(sout_e));
        chk({tag, ".fill"}, 64'(bus.fill_cnt), 64'(fill_e));
        chk({tag, ".full"}, 64'(bus.full), 64'(full_e));
    endtask

    logic [7:0] fill_seq [4];
    logic [7:0] rot_sout [4];
    logic [31:0] rot_pout [4];

    initial begin
        checks_total = 0;
        checks_pass  = 0;
        fill_seq = '{8'h11, 8'h22, 8'h33, 8'h44};
        rot_pout = '{32'h33221144, 32'h22114433, 32'h11443322, 32'h44332211};
        rot_sout = '{8'h33, 8'h22, 8'h11, 8'h44};

        // 1. Reset held with random inputs and a running clock.
        rst_b = 1'b0;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
        for (int i = 0; i < 3; i++) begin
            drive(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                  8'($urandom), $urandom);
            step();
            chk_all("rst_hold", 32'h0, 8'h00, 3'd0, 1'b0);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h9C, 32'h0);
        #2 rst_b = 1'b1;
        step();
        step();
        chk("pre_rst.fill", 64'(bus.fill_cnt), 64'd2);
        // Asynchronous assertion between edges while shifting.
        #3 rst_b = 1'b0;
        #1;
        chk_all("rst_async", 32'h0, 8'h00, 3'd0, 1'b0);
        #1 rst_b = 1'b1;

        // 2. Serial fill.
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, fill_seq[i], 32'h0);
            step();
            chk("fill.cnt", 64'(bus.fill_cnt), 64'(i + 1));
        end
        chk_all("fill4", 32'h11223344, 8'h11, 3'd4, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h55, 32'h0);
        step();
        chk_all("fill5", 32'h22334455, 8'h22, 3'd4, 1'b1);

        // 3. Parallel load and rotate (clear first so the load alone sets fill).
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h44332211);
        step();
        chk_all("load", 32'h44332211, 8'h44, 3'd4, 1'b1);
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'hEE, 32'h0);
            step();
            chk_all("rot", rot_pout[i], rot_sout[i], 3'd4, 1'b1);
        end

        // 4. Reverse shift.
        drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 32'h44332211);
        step();
        drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'hAA, 32'h0);
        step();
        chk("rev.pout", 64'(bus.pout), 64'h00000000AA443322);
        chk("rev.sout", 64'(bus.sout), 64'h22);

        // 5. Hold, then priority collisions.
        for (int i = 0; i < 5; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'(i * 8'h37), 32'h0);
            step();
            chk("hold.pout", 64'(bus.pout), 64'h00000000AA443322);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'h77, 32'h12345678);
        step();
        chk("clr_pri.pout", 64'(bus.pout), 64'h0);
        chk("clr_pri.fill", 64'(bus.fill_cnt), 64'h0);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h77, 32'hDEADBEEF);
        step();
        chk("ld_pri.pout", 64'(bus.pout), 64'h00000000DEADBEEF);
        chk("ld_pri.fill", 64'(bus.fill_cnt), 64'd4);

        // 6. Stall latency: marker on the first enabled edge, idle cycles interleaved.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 32'h0);
        step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h5A, 32'h0);
        step();
        chk("stall.sout1", 64'(bus.sout), 64'h00);
        for (int k = 2; k <= 4; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'hFF, 32'h0);
            step();
            drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 32'h0);
            step();
            chk("stall.sout", 64'(bus.sout), (k == 4) ? 64'h5A : 64'h00);
            chk("stall.fill", 64'(bus.fill_cnt), 64'(k));
        end

        $display("%0d/%0d checks passed", checks_pass, checks_total);
        $finish;
    end
endmodule
